id_exe_pipe_stage: RTL and testbench

- Parametrised successor to the decode stage.
- Performs operand selection, sign extension and the branch condition check.
- Adds RAW hazard detection (selectable forwarding mode), stall/freeze/bubble injection and a one-cycle branch squash.
- Registers all decoded results into an integrated ID/EXE pipeline register feeding EXE.
- Sits between the IF/ID register (plus the register file and control unit) and the EXE stage.

---
 rtl/id_exe_pipe_stage_if.sv | 59 +++++
 rtl/id_exe_pipe_stage.sv | 138 +++++++++++++
 tb/tb_id_exe_pipe_stage.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_exe_pipe_stage_if.sv
// Bundle of the decode-side inputs and the EXE-side pipeline-register outputs
// of id_exe_pipe_stage; clk/rst stay outside as plain ports.
interface id_exe_pipe_stage_if #(
    parameter int DATA_W = 32,
    parameter int CMD_W  = 4
);
    logic              id_valid;
    logic [31:0]       instruction;
    logic [DATA_W-1:0] id_pc;
    logic [DATA_W-1:0] reg1;
    logic [DATA_W-1:0] reg2;
    logic [CMD_W-1:0]  cu_exe_cmd;
    logic              cu_is_imm;
    logic              cu_st_or_bne;
    logic              cu_mem_r;
    logic              cu_mem_w;
    logic              cu_wb;
    logic              cu_br_en;
    logic [1:0]        cu_br_type;
    logic [4:0]        mem_dest;
    logic              mem_wb_en;
    logic              freeze;

    logic [4:0]        src1;
    logic [4:0]        src2;
    logic              br_taken;
    logic              id_stall;
    logic              exe_valid;
    logic              exe_mem_r;
    logic              exe_mem_w;
    logic              exe_wb;
    logic [CMD_W-1:0]  exe_cmd;
    logic [4:0]        exe_dest;
    logic [4:0]        exe_src1;
    logic [4:0]        exe_src2;
    logic [DATA_W-1:0] exe_val1;
    logic [DATA_W-1:0] exe_val2;
    logic [DATA_W-1:0] exe_reg2;
    logic [DATA_W-1:0] exe_pc;
    logic              dbg_squash;

    modport master (
        output id_valid, instruction, id_pc, reg1, reg2, cu_exe_cmd, cu_is_imm,
               cu_st_or_bne, cu_mem_r, cu_mem_w, cu_wb, cu_br_en, cu_br_type,
               mem_dest, mem_wb_en, freeze,
        input  src1, src2, br_taken, id_stall, exe_valid, exe_mem_r, exe_mem_w,
               exe_wb, exe_cmd, exe_dest, exe_src1, exe_src2, exe_val1,
               exe_val2, exe_reg2, exe_pc, dbg_squash
    );

    modport slave (
        input  id_valid, instruction, id_pc, reg1, reg2, cu_exe_cmd, cu_is_imm,
               cu_st_or_bne, cu_mem_r, cu_mem_w, cu_wb, cu_br_en, cu_br_type,
               mem_dest, mem_wb_en, freeze,
        output src1, src2, br_taken, id_stall, exe_valid, exe_mem_r, exe_mem_w,
               exe_wb, exe_cmd, exe_dest, exe_src1, exe_src2, exe_val1,
               exe_val2, exe_reg2, exe_pc, dbg_squash
    );
endinterface

// File: rtl/id_exe_pipe_stage.sv
// Decode stage with RAW hazard detection, bubble/stall/squash control and the
// ID/EXE pipeline register feeding EXE.
module id_exe_pipe_stage #(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    parameter int CMD_W  = 4,
    parameter int FWD_EN = 1
) (
    input logic clk,
    input logic rst,
    id_exe_pipe_stage_if.slave bus
);
    logic [4:0]        w_src1;
    logic [4:0]        w_src2;
    logic [4:0]        w_dest;
    logic [DATA_W-1:0] w_imm;
    logic [DATA_W-1:0] w_val2;
    logic              w_live;
    logic              w_uses1;
    logic              w_uses2;
    logic              w_hit_exe;
    logic              w_hit_mem;
    logic              w_hazard;
    logic              w_cond;
    logic              w_br_taken;

    logic              r_squash;
    logic              r_exe_valid;
    logic              r_exe_mem_r;
    logic              r_exe_mem_w;
    logic              r_exe_wb;
    logic [CMD_W-1:0]  r_exe_cmd;
    logic [4:0]        r_exe_dest;
    logic [4:0]        r_exe_src1;
    logic [4:0]        r_exe_src2;
    logic [DATA_W-1:0] r_exe_val1;
    logic [DATA_W-1:0] r_exe_val2;
    logic [DATA_W-1:0] r_exe_reg2;
    logic [DATA_W-1:0] r_exe_pc;

    assign w_src1 = bus.instruction[20:16];
    assign w_dest = bus.instruction[25:21];
    assign w_src2 = bus.cu_st_or_bne ? bus.instruction[25:21] : bus.instruction[15:11];
    assign w_imm  = {{(DATA_W-IMM_W){bus.instruction[IMM_W-1]}}, bus.instruction[IMM_W-1:0]};
    assign w_val2 = bus.cu_is_imm ? w_imm : bus.reg2;

    // The wrong-path instruction behind a taken branch is dead: no hazard, no branch.
    assign w_live  = bus.id_valid & ~r_squash;
    assign w_uses1 = ~(bus.cu_br_en & (bus.cu_br_type == 2'b10));
    assign w_uses2 = ~bus.cu_is_imm | bus.cu_st_or_bne;

    assign w_hit_exe =
        (w_uses1 & r_exe_valid & r_exe_wb & (r_exe_dest == w_src1) & (w_src1 != 5'd0)) |
        (w_uses2 & r_exe_valid & r_exe_wb & (r_exe_dest == w_src2) & (w_src2 != 5'd0));
    assign w_hit_mem =
        (w_uses1 & bus.mem_wb_en & (bus.mem_dest == w_src1) & (w_src1 != 5'd0)) |
        (w_uses2 & bus.mem_wb_en & (bus.mem_dest == w_src2) & (w_src2 != 5'd0));

    // Branches compare in ID, so they never benefit from EXE forwarding.
    always_comb begin
        w_hazard = 1'b0;
        if (FWD_EN == 0 || bus.cu_br_en)
            w_hazard = w_live & (w_hit_exe | w_hit_mem);
        else
            w_hazard = w_live & w_hit_exe & r_exe_mem_r;
    end

    always_comb begin
        w_cond = 1'b0;
        case (bus.cu_br_type)
            2'b00:   w_cond = (bus.reg1 == '0);
            2'b01:   w_cond = (bus.reg1 != bus.reg2);
            2'b10:   w_cond = 1'b1;
            default: w_cond = 1'b0;
        endcase
    end

    assign w_br_taken = w_live & bus.cu_br_en & w_cond & ~w_hazard & ~bus.freeze;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_squash    <= 1'b0;
            r_exe_valid <= 1'b0;
            r_exe_mem_r <= 1'b0;
            r_exe_mem_w <= 1'b0;
            r_exe_wb    <= 1'b0;
            r_exe_cmd   <= '0;
            r_exe_dest  <= '0;
            r_exe_src1  <= '0;
            r_exe_src2  <= '0;
            r_exe_val1  <= '0;
            r_exe_val2  <= '0;
            r_exe_reg2  <= '0;
            r_exe_pc    <= '0;
        end else if (bus.freeze) begin
            r_squash <= r_squash;
        end else if (w_hazard || !w_live) begin
            // Bubble: only the enables are cleared, payload fields keep their value.
            r_squash    <= 1'b0;
            r_exe_valid <= 1'b0;
            r_exe_mem_r <= 1'b0;
            r_exe_mem_w <= 1'b0;
            r_exe_wb    <= 1'b0;
        end else begin
            r_squash    <= w_br_taken;
            r_exe_valid <= 1'b1;
            r_exe_mem_r <= bus.cu_mem_r;
            r_exe_mem_w <= bus.cu_mem_w;
            r_exe_wb    <= bus.cu_wb;
            r_exe_cmd   <= bus.cu_exe_cmd;
            r_exe_dest  <= w_dest;
            r_exe_src1  <= w_src1;
            r_exe_src2  <= w_src2;
            r_exe_val1  <= bus.reg1;
            r_exe_val2  <= w_val2;
            r_exe_reg2  <= bus.reg2;
            r_exe_pc    <= bus.id_pc;
        end
    end

    assign bus.src1       = w_src1;
    assign bus.src2       = w_src2;
    assign bus.br_taken   = w_br_taken;
    assign bus.id_stall   = bus.freeze | w_hazard;
    assign bus.exe_valid  = r_exe_valid;
    assign bus.exe_mem_r  = r_exe_mem_r;
    assign bus.exe_mem_w  = r_exe_mem_w;
    assign bus.exe_wb     = r_exe_wb;
    assign bus.exe_cmd    = r_exe_cmd;
    assign bus.exe_dest   = r_exe_dest;
    assign bus.exe_src1   = r_exe_src1;
    assign bus.exe_src2   = r_exe_src2;
    assign bus.exe_val1   = r_exe_val1;
    assign bus.exe_val2   = r_exe_val2;
    assign bus.exe_reg2   = r_exe_reg2;
    assign bus.exe_pc     = r_exe_pc;
    assign bus.dbg_squash = r_squash;
endmodule

// File: tb/tb_id_exe_pipe_stage.sv
// Directed bench for id_exe_pipe_stage: one instance with forwarding, one without,
// both driven by the same stimulus; each check targets the instance it concerns.
module tb_id_exe_pipe_stage;
    logic clk;
    logic rst;

    logic        d_id_valid;
    logic [31:0] d_instruction;
    logic [31:0] d_id_pc;
    logic [31:0] d_reg1;
    logic [31:0] d_reg2;
    logic [3:0]  d_cmd;
    logic        d_is_imm;
    logic        d_st_or_bne;
    logic        d_mem_r;
    logic        d_mem_w;
    logic        d_wb;
    logic        d_br_en;
    logic [1:0]  d_br_type;
    logic [4:0]  d_mem_dest;
    logic        d_mem_wb_en;
    logic        d_freeze;

    int n_checks;
    int n_errors;

    id_exe_pipe_stage_if #(.DATA_W(32), .CMD_W(4)) f1_if ();
    id_exe_pipe_stage_if #(.DATA_W(32), .CMD_W(4)) f0_if ();

    assign f1_if.id_valid = d_id_valid;     assign f0_if.id_valid = d_id_valid;
    assign f1_if.instruction = d_instruction; assign f0_if.instruction = d_instruction;
    assign f1_if.id_pc = d_id_pc;           assign f0_if.id_pc = d_id_pc;
    assign f1_if.reg1 = d_reg1;             assign f0_if.reg1 = d_reg1;
    assign f1_if.reg2 = d_reg2;             assign f0_if.reg2 = d_reg2;
    assign f1_if.cu_exe_cmd = d_cmd;        assign f0_if.cu_exe_cmd = d_cmd;
    assign f1_if.cu_is_imm = d_is_imm;      assign f0_if.cu_is_imm = d_is_imm;
    assign f1_if.cu_st_or_bne = d_st_or_bne; assign f0_if.cu_st_or_bne = d_st_or_bne;
    assign f1_if.cu_mem_r = d_mem_r;        assign f0_if.cu_mem_r = d_mem_r;
    assign f1_if.cu_mem_w = d_mem_w;        assign f0_if.cu_mem_w = d_mem_w;
    assign f1_if.cu_wb = d_wb;              assign f0_if.cu_wb = d_wb;
    assign f1_if.cu_br_en = d_br_en;        assign f0_if.cu_br_en = d_br_en;
    assign f1_if.cu_br_type = d_br_type;    assign f0_if.cu_br_type = d_br_type;
    assign f1_if.mem_dest = d_mem_dest;     assign f0_if.mem_dest = d_mem_dest;
    assign f1_if.mem_wb_en = d_mem_wb_en;   assign f0_if.mem_wb_en = d_mem_wb_en;
    assign f1_if.freeze = d_freeze;         assign f0_if.freeze = d_freeze;

    id_exe_pipe_stage #(.DATA_W(32), .IMM_W(16), .CMD_W(4), .FWD_EN(1)) u1 (
        .clk(clk), .rst(rst), .bus(f1_if)
    );
    id_exe_pipe_stage #(.DATA_W(32), .IMM_W(16), .CMD_W(4), .FWD_EN(0)) u0 (
        .clk(clk), .rst(rst), .bus(f0_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic [31:0] ins;
        logic [31:0] r1;
        logic [31:0] r2;
        logic        imm;
        logic        sob;
        logic        mr;
        logic        wb;
        logic        br;
        logic [1:0]  bt;
        logic        e_stall;
        logic        e_br;
        logic        e_valid;
        logic        e_wb;
        logic [4:0]  e_dest;
        logic [31:0] e_v1;
        logic [31:0] e_v2;
    } vec_t;

    vec_t tbl[16];

    function automatic logic [31:0] mk_r(input logic [4:0] d, input logic [4:0] s1,
                                         input logic [4:0] s2);
        return {6'd0, d, s1, s2, 11'd0};
    endfunction

    function automatic logic [31:0] mk_i(input logic [4:0] d, input logic [4:0] s1,
                                         input logic [15:0] imm);
        return {6'd0, d, s1, imm};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        d_id_valid = 1'b0; d_instruction = 32'd0; d_id_pc = 32'd0;
        d_reg1 = 32'd0; d_reg2 = 32'd0; d_cmd = 4'd0;
        d_is_imm = 1'b0; d_st_or_bne = 1'b0; d_mem_r = 1'b0; d_mem_w = 1'b0;
        d_wb = 1'b0; d_br_en = 1'b0; d_br_type = 2'b00;
        d_mem_dest = 5'd0; d_mem_wb_en = 1'b0; d_freeze = 1'b0;
    endtask

    task automatic check_zero_u1(input string tag);
        check({tag, "_u1_ctl"}, 32'({f1_if.exe_valid, f1_if.exe_wb, f1_if.exe_mem_r,
              f1_if.exe_mem_w, f1_if.exe_cmd, f1_if.exe_dest, f1_if.exe_src1,
              f1_if.exe_src2}), 32'd0);
        check({tag, "_u1_val1"}, f1_if.exe_val1, 32'd0);
        check({tag, "_u1_val2"}, f1_if.exe_val2, 32'd0);
        check({tag, "_u1_reg2"}, f1_if.exe_reg2, 32'd0);
        check({tag, "_u1_pc"}, f1_if.exe_pc, 32'd0);
    endtask

    task automatic check_zero_u0(input string tag);
        check({tag, "_u0_ctl"}, 32'({f0_if.exe_valid, f0_if.exe_wb, f0_if.exe_mem_r,
              f0_if.exe_mem_w, f0_if.exe_cmd, f0_if.exe_dest, f0_if.exe_src1,
              f0_if.exe_src2}), 32'd0);
        check({tag, "_u0_vals"}, f0_if.exe_val1 | f0_if.exe_val2 | f0_if.exe_reg2 |
              f0_if.exe_pc, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle();
        tick();
        tick();
        check_zero_u1("reset");
        check_zero_u0("reset");
        rst = 1'b1;
    endtask

    task automatic apply(input vec_t v);
        idle();
        d_id_valid = v.vld; d_instruction = v.ins; d_reg1 = v.r1; d_reg2 = v.r2;
        d_is_imm = v.imm; d_st_or_bne = v.sob; d_mem_r = v.mr; d_wb = v.wb;
        d_br_en = v.br; d_br_type = v.bt;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b0;
        idle();

        // vld ins r1 r2 | imm sob mr wb br bt | stall br valid wb dest val1 val2
        tbl[0]  = '{1'b1, mk_r(5'd3, 5'd1, 5'd2), 32'd5, 32'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00,
                    1'b0, 1'b0, 1'b1, 1'b1, 5'd3, 32'd5, 32'd7};
        tbl[1]  = '{1'b1, mk_i(5'd4, 5'd1, 16'h0008), 32'd5, 32'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00,
                    1'b0, 1'b0, 1'b1, 1'b1, 5'd4, 32'd5, 32'd8};
        tbl[2]  = '{1'b1, mk_r(5'd5, 5'd4, 5'd2), 32'd9, 32'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00,
                    1'b1, 1'b0, 1'b0, 1'b0, 5'd4, 32'd5, 32'd8};
        tbl[3]  = '{1'b1, mk_r(5'd5, 5'd4, 5'd2), 32'd9, 32'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00,
                    1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 32'd9, 32'd1};
        tbl[4]  = '{1'b1, mk_r(5'd6, 5'd5, 5'd0), 32'd3, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00,
                    1'b0, 1'b0, 1'b1, 1'b1, 5'd6, 32'd3, 32'd0};
        tbl[5]  = '{1'b1, mk_i(5'd7, 5'd0, 16'h8000), 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00,
                    1'b0, 1'b0, 1'b1, 1'b1, 5'd7, 32'd0, 32'hFFFF8000};
        tbl[6]  = '{1'b1, mk_i(5'd8, 5'd0, 16'h7FFF), 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00,
                    1'b0, 1'b0, 1'b1, 1'b1, 5'd8, 32'd0, 32'h00007FFF};
        tbl[7]  = '{1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00,
                    1'b0, 1'b0, 1'b0, 1'b0, 5'd8, 32'd0, 32'h00007FFF};
        tbl[8]  = '{1'b1, mk_r(5'd2, 5'd1, 5'd0), 32'd1, 32'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01,
                    1'b0, 1'b1, 1'b1, 1'b0, 5'd2, 32'd1, 32'd2};
        tbl[9]  = '{1'b1, mk_r(5'd9, 5'd1, 5'd2), 32'd5, 32'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00,
                    1'b0, 1'b0, 1'b0, 1'b0, 5'd2, 32'd1, 32'd2};
        tbl[10] = '{1'b1, mk_r(5'd10, 5'd3, 5'd4), 32'd11, 32'd12, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00,
                    1'b0, 1'b0, 1'b1, 1'b1, 5'd10, 32'd11, 32'd12};
        tbl[11] = '{1'b1, mk_r(5'd0, 5'd1, 5'd0), 32'd1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00,
                    1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'd1, 32'd0};
        tbl[12] = '{1'b1, mk_r(5'd11, 5'd2, 5'd3), 32'd4, 32'd6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00,
                    1'b0, 1'b0, 1'b1, 1'b1, 5'd11, 32'd4, 32'd6};
        tbl[13] = '{1'b1, mk_r(5'd0, 5'd11, 5'd0), 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00,
                    1'b1, 1'b0, 1'b0, 1'b0, 5'd11, 32'd4, 32'd6};
        tbl[14] = '{1'b1, mk_r(5'd0, 5'd11, 5'd0), 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00,
                    1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0, 32'd0};
        tbl[15] = '{1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00,
                    1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0};

        // Table: forwarding instance, back-to-back vectors.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            apply(tbl[i]);
            #1;
            check($sformatf("v%0d_stall", i), 32'(f1_if.id_stall), 32'(tbl[i].e_stall));
            check($sformatf("v%0d_br", i), 32'(f1_if.br_taken), 32'(tbl[i].e_br));
            tick();
            check($sformatf("v%0d_valid", i), 32'(f1_if.exe_valid), 32'(tbl[i].e_valid));
            check($sformatf("v%0d_wb", i), 32'(f1_if.exe_wb), 32'(tbl[i].e_wb));
            check($sformatf("v%0d_dest", i), 32'(f1_if.exe_dest), 32'(tbl[i].e_dest));
            check($sformatf("v%0d_val1", i), f1_if.exe_val1, tbl[i].e_v1);
            check($sformatf("v%0d_val2", i), f1_if.exe_val2, tbl[i].e_v2);
        end

        // No-forwarding instance: RAW with EXE, then with MEM, then r0 producer.
        do_reset();
        idle();
        d_id_valid = 1'b1; d_instruction = mk_r(5'd4, 5'd1, 5'd2); d_wb = 1'b1;
        #1;
        check("u0_add_stall", 32'(f0_if.id_stall), 32'd0);
        tick();
        check("u0_add_valid", 32'(f0_if.exe_valid), 32'd1);
        check("u0_add_dest", 32'(f0_if.exe_dest), 32'd4);
        d_instruction = mk_r(5'd5, 5'd1, 5'd4);
        #1;
        check("u0_raw_exe_stall", 32'(f0_if.id_stall), 32'd1);
        check("u1_nonload_nostall", 32'(f1_if.id_stall), 32'd0);
        tick();
        check("u0_bubble1_valid", 32'(f0_if.exe_valid), 32'd0);
        d_mem_dest = 5'd4; d_mem_wb_en = 1'b1;
        #1;
        check("u0_raw_mem_stall", 32'(f0_if.id_stall), 32'd1);
        tick();
        check("u0_bubble2_valid", 32'(f0_if.exe_valid), 32'd0);
        d_mem_wb_en = 1'b0;
        #1;
        check("u0_sub_stall", 32'(f0_if.id_stall), 32'd0);
        tick();
        check("u0_sub_valid", 32'(f0_if.exe_valid), 32'd1);
        check("u0_sub_dest", 32'(f0_if.exe_dest), 32'd5);
        d_instruction = mk_r(5'd0, 5'd1, 5'd2);
        tick();
        d_instruction = mk_r(5'd6, 5'd0, 5'd0); d_mem_dest = 5'd0; d_mem_wb_en = 1'b1;
        #1;
        check("u0_r0_stall", 32'(f0_if.id_stall), 32'd0);
        tick();
        check("u0_r0_valid", 32'(f0_if.exe_valid), 32'd1);
        check("u0_r0_dest", 32'(f0_if.exe_dest), 32'd6);

        // Forwarding instance: load, then freeze over a load-use branch, reset mid-freeze.
        do_reset();
        idle();
        d_id_valid = 1'b1; d_instruction = mk_i(5'd4, 5'd1, 16'h0010); d_is_imm = 1'b1;
        d_mem_r = 1'b1; d_wb = 1'b1; d_cmd = 4'd9; d_id_pc = 32'h100;
        d_reg1 = 32'h20; d_reg2 = 32'h33;
        tick();
        check("ld_mem_r", 32'(f1_if.exe_mem_r), 32'd1);
        check("ld_mem_w", 32'(f1_if.exe_mem_w), 32'd0);
        check("ld_cmd", 32'(f1_if.exe_cmd), 32'd9);
        check("ld_pc", f1_if.exe_pc, 32'h100);
        check("ld_src1", 32'(f1_if.exe_src1), 32'd1);
        check("ld_src2", 32'(f1_if.exe_src2), 32'd0);
        check("ld_val1", f1_if.exe_val1, 32'h20);
        check("ld_val2", f1_if.exe_val2, 32'h10);
        check("ld_reg2", f1_if.exe_reg2, 32'h33);
        idle();
        d_id_valid = 1'b1; d_instruction = mk_r(5'd0, 5'd4, 5'd0); d_br_en = 1'b1;
        d_br_type = 2'b00; d_id_pc = 32'h104; d_freeze = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("frz%0d_stall", c), 32'(f1_if.id_stall), 32'd1);
            check($sformatf("frz%0d_br", c), 32'(f1_if.br_taken), 32'd0);
            tick();
            check($sformatf("frz%0d_valid", c), 32'(f1_if.exe_valid), 32'd1);
            check($sformatf("frz%0d_dest", c), 32'(f1_if.exe_dest), 32'd4);
            check($sformatf("frz%0d_mem_r", c), 32'(f1_if.exe_mem_r), 32'd1);
            check($sformatf("frz%0d_pc", c), f1_if.exe_pc, 32'h100);
        end
        rst = 1'b0;
        tick();
        check_zero_u1("frz_rst");
        check_zero_u0("frz_rst");
        rst = 1'b1; d_freeze = 1'b0;
        #1;
        check("post_rst_stall", 32'(f1_if.id_stall), 32'd0);
        check("post_rst_br", 32'(f1_if.br_taken), 32'd1);
        tick();
        check("post_rst_valid", 32'(f1_if.exe_valid), 32'd1);
        check("post_rst_wb", 32'(f1_if.exe_wb), 32'd0);
        check("post_rst_pc", f1_if.exe_pc, 32'h104);
        check("post_rst_squash", 32'(f1_if.dbg_squash), 32'd1);
        idle();
        d_id_valid = 1'b1; d_instruction = mk_r(5'd9, 5'd1, 5'd2); d_wb = 1'b1;
        tick();
        check("squashed_valid", 32'(f1_if.exe_valid), 32'd0);
        check("squash_cleared", 32'(f1_if.dbg_squash), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
